// File: rtl/pc_redirect_ctrl.sv
// Redirect sequencer between execute/trap sources and the fetch PC mux: arbitration, flush, BTB update.
// Optional macro PC_REDIRECT_PERF_EN adds branch/mispredict/trap performance counters.
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_modify_pc,
  input  logic [31:0] ex_update_pc,
  input  logic        ex_update_btb,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_jump_addr,
  input  logic        ex_taken,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  output logic        trap_ack,
  input  logic        fetch_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_front,
  output logic        flush_ex,
  output logic        btb_wr_en,
  output logic [31:0] btb_wr_pc,
  output logic [31:0] btb_wr_target,
  output logic        btb_wr_taken,
  output logic        busy
`ifdef PC_REDIRECT_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts,
  output logic [CNT_W-1:0] perf_traps
`endif
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_bad_param
    $error("pc_redirect_ctrl: FLUSH_CYCLES must be 1..15 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        trap_ack_q;
  logic        flush_ex_q;
  logic        btb_wr_en_q;
  logic [31:0] btb_wr_pc_q, btb_wr_target_q;
  logic        btb_wr_taken_q;

  logic ex_ev, trap_ev, btb_ev, mispredict_ev;

  // The acknowledge cycle masks the still-held trap level so one request yields one ack.
  assign trap_ev       = trap_req & ~trap_ack_q;
  assign ex_ev         = ex_valid & ex_modify_pc & ~flush_ex_q;
  assign btb_ev        = ex_valid & ex_update_btb & ~flush_ex_q;
  assign mispredict_ev = ex_ev & ~trap_ev & (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (trap_ev) begin
          state_d       = REQ;
          redirect_pc_d = trap_vec;
        end else if (ex_ev) begin
          state_d       = REQ;
          redirect_pc_d = ex_update_pc;
        end
      end
      REQ: begin
        if (trap_ev) redirect_pc_d = trap_vec;
        if (fetch_ready) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      DRAIN: begin
        if (trap_ev) begin
          state_d       = REQ;
          redirect_pc_d = trap_vec;
        end else if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = (state_q == REQ);
    busy           = (state_q != IDLE);
  end

  // Registered flush/ack/data; flush tracks the registered "not idle" condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q           <= 4'd0;
      redirect_pc_q   <= 32'd0;
      trap_ack_q      <= 1'b0;
      flush_ex_q      <= 1'b0;
      btb_wr_en_q     <= 1'b0;
      btb_wr_pc_q     <= 32'd0;
      btb_wr_target_q <= 32'd0;
      btb_wr_taken_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
      trap_ack_q    <= trap_ev;
      flush_ex_q    <= (state_d != IDLE);
      btb_wr_en_q   <= btb_ev;
      if (btb_ev) begin
        btb_wr_pc_q     <= ex_pc;
        btb_wr_target_q <= ex_jump_addr;
        btb_wr_taken_q  <= ex_taken;
      end
    end
  end

  assign redirect_pc   = redirect_pc_q;
  assign trap_ack      = trap_ack_q;
  assign flush_front   = flush_ex_q;
  assign flush_ex      = flush_ex_q;
  assign btb_wr_en     = btb_wr_en_q;
  assign btb_wr_pc     = btb_wr_pc_q;
  assign btb_wr_target = btb_wr_target_q;
  assign btb_wr_taken  = btb_wr_taken_q;

`ifdef PC_REDIRECT_PERF_EN
  logic [CNT_W-1:0] perf_branches_q, perf_mispredicts_q, perf_traps_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q    <= '0;
      perf_mispredicts_q <= '0;
      perf_traps_q       <= '0;
    end else begin
      if (btb_ev)        perf_branches_q    <= perf_branches_q + 1'b1;
      if (mispredict_ev) perf_mispredicts_q <= perf_mispredicts_q + 1'b1;
      if (trap_ev)       perf_traps_q       <= perf_traps_q + 1'b1;
    end
  end

  assign perf_branches    = perf_branches_q;
  assign perf_mispredicts = perf_mispredicts_q;
  assign perf_traps       = perf_traps_q;
`else
  logic unused_mispredict;
  assign unused_mispredict = mispredict_ev;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed redirect, trap, backpressure, BTB and reset cases.
module tb_pc_redirect_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_modify_pc, ex_update_btb, ex_taken;
  logic [31:0] ex_update_pc, ex_pc, ex_jump_addr;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        trap_ack;
  logic        fetch_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_front, flush_ex;
  logic        btb_wr_en;
  logic [31:0] btb_wr_pc, btb_wr_target;
  logic        btb_wr_taken;
  logic        busy;
`ifdef PC_REDIRECT_PERF_EN
  logic [CNT_W-1:0] perf_branches, perf_mispredicts, perf_traps;
`endif

  pc_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_modify_pc(ex_modify_pc), .ex_update_pc(ex_update_pc),
    .ex_update_btb(ex_update_btb), .ex_pc(ex_pc), .ex_jump_addr(ex_jump_addr),
    .ex_taken(ex_taken), .trap_req(trap_req), .trap_vec(trap_vec), .trap_ack(trap_ack),
    .fetch_ready(fetch_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_front(flush_front), .flush_ex(flush_ex), .btb_wr_en(btb_wr_en),
    .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target), .btb_wr_taken(btb_wr_taken),
    .busy(busy)
`ifdef PC_REDIRECT_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts), .perf_traps(perf_traps)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_br = 0, exp_mis = 0, exp_trap = 0;

  logic [31:0] q_redir[$];
  logic [31:0] q_trap[$];
  logic [64:0] q_btb[$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    ex_valid = 0; ex_modify_pc = 0; ex_update_btb = 0; ex_taken = 0;
    ex_update_pc = 0; ex_pc = 0; ex_jump_addr = 0;
    trap_req = 0; trap_vec = 0;
  endtask

  task automatic ex_redirect(input logic [31:0] pc);
    ex_valid = 1; ex_modify_pc = 1; ex_update_pc = pc;
    q_redir.push_back(pc);
    exp_mis++;
  endtask

  task automatic trap(input logic [31:0] vec);
    trap_req = 1; trap_vec = vec;
    q_trap.push_back(vec);
    q_redir.push_back(vec);
    exp_trap++;
  endtask

  task automatic btb(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic expect_wr);
    ex_valid = 1; ex_update_btb = 1; ex_pc = pc; ex_jump_addr = tgt; ex_taken = tk;
    if (expect_wr) begin
      q_btb.push_back({pc, tgt, tk});
      exp_br++;
    end
  endtask

  // Caller has raised fetch_ready; counts cycles with flush high until the block is idle again.
  task automatic run_to_idle(input string name);
    int nflush = 0;
    int guard  = 0;
    while ((flush_front || busy) && guard < 40) begin
      if (flush_front) nflush++;
      tick();
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, guard);
    end
    check({name, "_flush_len"}, 65'(nflush), 65'(1 + FLUSH_CYCLES));
    check({name, "_idle"}, {64'd0, busy}, 65'd0);
    fetch_ready = 0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (redirect_valid && fetch_ready) begin
        if (q_redir.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL redir_unexpected: got pc %h, none expected", redirect_pc);
        end else begin
          check("redir_pc", 65'(redirect_pc), 65'(q_redir.pop_front()));
        end
      end
      if (trap_ack) begin
        if (q_trap.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL trap_ack_unexpected: got ack with pc %h, none expected", redirect_pc);
        end else begin
          check("trap_ack_pc", 65'(redirect_pc), 65'(q_trap.pop_front()));
        end
      end
      if (btb_wr_en) begin
        if (q_btb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL btb_unexpected: got pc %h tgt %h", btb_wr_pc, btb_wr_target);
        end else begin
          check("btb_write", {btb_wr_pc, btb_wr_target, btb_wr_taken}, q_btb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1; fetch_ready = 0; clr_in();
    tick(); tick();
    rst = 0;
    check("rst_ctrl", {59'd0, redirect_valid, flush_front, flush_ex, btb_wr_en, trap_ack, busy}, 65'd0);
    check("rst_data", {1'b0, redirect_pc, btb_wr_pc}, 65'd0);
    check("rst_btb", {btb_wr_taken, btb_wr_target, 32'd0}, 65'd0);

    // Plain execute redirect accepted immediately
    ex_redirect(32'h100);
    tick(); clr_in();
    check("ex_valid", {64'd0, redirect_valid}, 65'd1);
    check("ex_pc", 65'(redirect_pc), 65'h100);
    check("ex_flush", {63'd0, flush_front, flush_ex}, 65'd3);
    fetch_ready = 1;
    run_to_idle("ex");

    // Backpressure with ignored execute noise during the flush
    ex_redirect(32'h100);
    tick(); clr_in();
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1; ex_modify_pc = 1; ex_update_pc = 32'hDEAD;
      check("bp_hold", {redirect_valid, redirect_pc}, {1'b1, 32'h100});
      tick();
    end
    clr_in();
    check("bp_still_req", {redirect_valid, redirect_pc}, {1'b1, 32'h100});
    fetch_ready = 1;
    run_to_idle("bp");

    // Trap wins over a simultaneous execute redirect
    trap(32'h8000_0000);
    ex_valid = 1; ex_modify_pc = 1; ex_update_pc = 32'h200;
    tick(); clr_in();
    check("trap_prio_pc", {trap_ack, redirect_pc}, {1'b1, 32'h8000_0000});
    fetch_ready = 1;
    run_to_idle("trap_prio");

    // Trap overwrites a pending execute redirect without a valid gap
    ex_valid = 1; ex_modify_pc = 1; ex_update_pc = 32'h300; exp_mis++;
    tick(); clr_in();
    check("ovr_first", {redirect_valid, redirect_pc}, {1'b1, 32'h300});
    trap(32'h400);
    tick(); clr_in();
    check("ovr_switch", {trap_ack, redirect_valid, redirect_pc}, {2'b11, 32'h400});
    tick();
    check("ovr_single_ack", {trap_ack, redirect_valid, redirect_pc}, {2'b01, 32'h400});
    fetch_ready = 1;
    run_to_idle("ovr");

    // Trap during DRAIN re-enters REQ
    ex_redirect(32'h600);
    tick(); clr_in();
    fetch_ready = 1;
    tick();
    fetch_ready = 0;
    check("drain_state", {busy, redirect_valid}, 65'b10);
    trap(32'h700);
    tick(); clr_in();
    check("drain_trap", {trap_ack, redirect_valid, redirect_pc}, {2'b11, 32'h700});
    fetch_ready = 1;
    run_to_idle("drain_trap");

    // BTB write without redirect
    btb(32'h40, 32'h80, 1'b1, 1'b1);
    tick(); clr_in();
    check("btb_plain", {btb_wr_en, busy, btb_wr_pc, btb_wr_taken}, {2'b10, 32'h40, 1'b1});
    tick();
    check("btb_once", {64'd0, btb_wr_en}, 65'd0);

    // BTB write alongside a redirect; a follow-up during flush is dropped
    btb(32'h50, 32'h90, 1'b0, 1'b1);
    ex_redirect(32'h90);
    tick(); clr_in();
    check("btb_redir", {btb_wr_en, redirect_valid, btb_wr_pc}, {2'b11, 32'h50});
    btb(32'h60, 32'hB0, 1'b1, 1'b0);
    tick(); clr_in();
    check("btb_flushed", {64'd0, btb_wr_en}, 65'd0);
    fetch_ready = 1;
    run_to_idle("btb_redir");

    // Trap does not suppress a same-cycle BTB write
    trap(32'h500);
    btb(32'h70, 32'hA0, 1'b1, 1'b1);
    tick(); clr_in();
    check("btb_trap", {btb_wr_en, trap_ack, btb_wr_pc}, {2'b11, 32'h70});
    fetch_ready = 1;
    run_to_idle("btb_trap");

`ifdef PC_REDIRECT_PERF_EN
    check("perf_br", 65'(perf_branches), 65'(exp_br));
    check("perf_mis", 65'(perf_mispredicts), 65'(exp_mis));
    check("perf_trap", 65'(perf_traps), 65'(exp_trap));
`endif

    // Reset while a redirect is pending, with a trap in the same cycle
    ex_valid = 1; ex_modify_pc = 1; ex_update_pc = 32'h900;
    tick(); clr_in();
    check("pre_rst_req", {redirect_valid, redirect_pc}, {1'b1, 32'h900});
    rst = 1; trap_req = 1; trap_vec = 32'hC00;
    tick();
    rst = 0; clr_in();
    check("mid_rst_ctrl", {59'd0, redirect_valid, flush_front, flush_ex, btb_wr_en, trap_ack, busy}, 65'd0);
    check("mid_rst_pc", 65'(redirect_pc), 65'd0);
`ifdef PC_REDIRECT_PERF_EN
    check("mid_rst_perf", 65'(perf_branches | perf_mispredicts | perf_traps), 65'd0);
`endif
    tick();
    check("post_rst_idle", {62'd0, trap_ack, redirect_valid, busy}, 65'd0);
    tick();

    check("q_redir_empty", 65'(q_redir.size()), 65'd0);
    check("q_trap_empty", 65'(q_trap.size()), 65'd0);
    check("q_btb_empty", 65'(q_btb.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
